aec_share_arb: RTL and testbench

Two-requester arbiter and sequencer that time-shares one `AEC` arithmetic-expression core. It grants the core to one requester at a time using round-robin priority. It pulls the owner's ASCII expression one character per cycle and drives the core's `ready`/`ascii_in` stream. It then waits for the core's `valid`, and returns the 7-bit result to the owner with a completion pulse and an error flag.

---
 rtl/aec_pkg.sv | 6 +
 rtl/rr_pick2.sv | 11 +
 rtl/aec_share_arb.sv | 120 ++++++++++++
 tb/tb_aec_share_arb.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aec_pkg.sv
// aec_pkg: shared constants and arbiter state encoding for the AEC share arbiter
package aec_pkg;
    localparam logic [7:0] ASCII_EQ = 8'h3D;
    localparam int RES_W = 7;
    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} arb_state_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker
//   req  in  2  request bits
//   ptr  in  1  requester holding priority
//   gnt  out 2  one-hot grant, 0 when nobody requests
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);
    always_comb gnt = req[ptr] ? (ptr ? 2'b10 : 2'b01) : req[!ptr] ? (ptr ? 2'b01 : 2'b10) : 2'b00;
endmodule

// File: rtl/aec_share_arb.sv
// aec_share_arb: round-robin arbiter time-sharing one AEC core between two requesters
//   clk, rst            clock and synchronous active-high reset
//   req, chr0, chr1     requests and current character of each requester
//   chr_pop             advance the owner's character stream
//   core_ready/ascii    character stream to the core
//   core_valid/result   core result strobe and value
//   grant, done         one-hot owner and completion pulse
//   result, err         returned result and forced-terminator/timeout flag
module aec_share_arb
    import aec_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [7:0]       chr0,
    input  logic [7:0]       chr1,
    output logic [1:0]       chr_pop,
    output logic             core_ready,
    output logic [7:0]       core_ascii,
    input  logic             core_valid,
    input  logic [RES_W-1:0] core_result,
    output logic [1:0]       grant,
    output logic [1:0]       done,
    output logic [RES_W-1:0] result,
    output logic             err
);
    localparam int CW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT);

    arb_state_t       state_q;
    logic             ptr_q;
    logic [CW-1:0]    cnt_q;
    logic [TW-1:0]    tmo_q;
    logic             err_sticky_q;
    logic [1:0]       grant_q;
    logic [1:0]       grant_d;
    logic             core_ready_q;
    logic [7:0]       core_ascii_q;
    logic [1:0]       done_q;
    logic [RES_W-1:0] result_q;
    logic             err_q;
    logic             force_eq;
    logic [7:0]       cur_chr;

    rr_pick2 u_pick (.req(req), .ptr(ptr_q), .gnt(grant_d));

    // Out of budget without '=': this cycle injects the terminator instead of popping
    assign force_eq = state_q == SEND && cnt_q == CNT_LAST;
    assign cur_chr  = grant_q[1] ? chr1 : chr0;
    assign chr_pop  = (state_q == SEND && !force_eq) ? grant_q : 2'b00;

    assign grant      = grant_q;
    assign core_ready = core_ready_q;
    assign core_ascii = core_ascii_q;
    assign done       = done_q;
    assign result     = result_q;
    assign err        = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            cnt_q        <= '0;
            tmo_q        <= '0;
            err_sticky_q <= 1'b0;
            grant_q      <= 2'b00;
            core_ready_q <= 1'b0;
            core_ascii_q <= 8'h00;
            done_q       <= 2'b00;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            core_ready_q <= 1'b0;
            done_q       <= 2'b00;
            case (state_q)
                IDLE: if (|req) begin
                    grant_q <= grant_d;
                    state_q <= SEND;
                end
                SEND: begin
                    core_ready_q <= cnt_q == '0;
                    core_ascii_q <= force_eq ? ASCII_EQ : cur_chr;
                    cnt_q        <= cnt_q + 1'b1;
                    if (force_eq) err_sticky_q <= 1'b1;
                    if (force_eq || cur_chr == ASCII_EQ) state_q <= WAIT;
                end
                WAIT: if (core_valid) begin
                    result_q <= core_result;
                    done_q   <= grant_q;
                    err_q    <= err_sticky_q;
                    state_q  <= DONE;
                end else if (tmo_q == TMO_LAST) begin
                    result_q     <= '0;
                    err_sticky_q <= 1'b1;
                    done_q       <= grant_q;
                    err_q        <= 1'b1;
                    state_q      <= DONE;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
                DONE: begin
                    // Priority passes to the requester that was not just served
                    ptr_q        <= grant_q[0];
                    grant_q      <= 2'b00;
                    cnt_q        <= '0;
                    tmo_q        <= '0;
                    err_sticky_q <= 1'b0;
                    err_q        <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aec_share_arb.sv
// tb_aec_share_arb: scoreboard bench with requester and core models for aec_share_arb
module tb_aec_share_arb;
    import aec_pkg::*;
    localparam int ML = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [7:0] chr0, chr1;
    logic [1:0] chr_pop, grant, done;
    logic core_ready, core_valid, err;
    logic [7:0] core_ascii;
    logic [6:0] result;
    logic model_valid = 1'b0;
    logic stray_valid = 1'b0;
    logic [6:0] model_val = 7'd0;

    typedef struct {int owner; int res; int err; string s; int pops; int lat;} exp_t;
    typedef struct {string name; int got; int want;} chk_t;
    exp_t exp_q[$];
    chk_t chk_q[$];
    int core_vals[$];

    int nvec = 0, nfail = 0;
    int cyc = 0;
    int idx0 = 0, idx1 = 0, base0 = 0, base1 = 0;
    string str0 = "", str1 = "";
    string coll = "", last_str = "";
    int collecting = 0, vcnt = 0, eq_cyc = 0, v;
    int last0 = 0, last1 = 0;

    always #5 clk = ~clk;
    assign core_valid = model_valid | stray_valid;

    aec_share_arb #(.MAX_LEN(ML), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .chr0(chr0), .chr1(chr1), .chr_pop(chr_pop),
        .core_ready(core_ready), .core_ascii(core_ascii), .core_valid(core_valid),
        .core_result(model_val), .grant(grant), .done(done), .result(result), .err(err)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (chr_pop[0]) idx0 <= idx0 + 1;
        if (chr_pop[1]) idx1 <= idx1 + 1;
    end

    always_comb begin
        chr0 = (str0.len() > 0) ? str0[(idx0 - base0) % str0.len()] : 8'h00;
        chr1 = (str1.len() > 0) ? str1[(idx1 - base1) % str1.len()] : 8'h00;
    end

    always @(negedge clk) begin
        model_valid = 1'b0;
        if (rst) begin
            collecting = 0;
            vcnt = 0;
        end else begin
            if (vcnt > 0) begin
                vcnt--;
                if (vcnt == 0) model_valid = 1'b1;
            end
            if (core_ready) begin
                coll = "";
                collecting = 1;
            end
            if (collecting != 0) begin
                coll = {coll, $sformatf("%c", core_ascii)};
                if (core_ascii == ASCII_EQ) begin
                    collecting = 0;
                    last_str = coll;
                    eq_cyc = cyc;
                    v = (core_vals.size() > 0) ? core_vals.pop_front() : -1;
                    if (v >= 0) begin
                        vcnt = 2;
                        model_val = 7'(v);
                    end
                end
            end
        end
    end

    task automatic cmp(input string n, input int g, input int w);
        nvec++;
        if (g != w) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", n, g, w);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk_t c;
        int pops;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            cmp(c.name, c.got, c.want);
        end
        if ($countones(grant) > 1) begin
            nfail++;
            $display("FAIL grant_onehot: got %b, expected at most one bit set", grant);
        end
        if (rst) begin
            last0 = idx0;
            last1 = idx1;
        end else if (done != 2'b00) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL unexpected_done: got done=%b, expected no completion", done);
            end else begin
                e = exp_q.pop_front();
                pops = (e.owner != 0) ? idx1 - last1 : idx0 - last0;
                if (e.owner != 0) last1 = idx1; else last0 = idx0;
                cmp("done", int'(done), 1 << e.owner);
                cmp("grant", int'(grant), 1 << e.owner);
                cmp("result", int'(result), e.res);
                cmp("err", int'(err), e.err);
                cmp("pops", pops, e.pops);
                cmp("latency", cyc - eq_cyc, e.lat);
                nvec++;
                if (last_str != e.s) begin
                    nfail++;
                    $display("FAIL core_string: got \"%s\", expected \"%s\"", last_str, e.s);
                end
            end
        end
    end

    task automatic push(input string n, input int g, input int w);
        chk_q.push_back('{n, g, w});
    endtask

    task automatic expect_tx(input int o, input int r, input int e, input string s, input int p, input int l);
        exp_q.push_back('{o, r, e, s, p, l});
    endtask

    task automatic load(input int i, input string s);
        if (i == 0) begin
            str0 = s;
            base0 = idx0;
        end else begin
            str1 = s;
            base1 = idx1;
        end
    endtask

    task automatic wait_dones(input int n);
        int k = 0;
        int t = 0;
        while (k < n && t < 300) begin
            @(negedge clk);
            t++;
            if (done != 2'b00) k++;
        end
        if (k < n) push("done_timeout", k, n);
    endtask

    task automatic wait_pop(input int i);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!chr_pop[i] && t < 50);
        if (!chr_pop[i]) push("pop_timeout", 0, 1);
    endtask

    task automatic check_idle_zero(input string tag);
        push({tag, "_grant"}, int'(grant), 0);
        push({tag, "_done"}, int'(done), 0);
        push({tag, "_core_ready"}, int'(core_ready), 0);
        push({tag, "_core_ascii"}, int'(core_ascii), 0);
        push({tag, "_result"}, int'(result), 0);
        push({tag, "_err"}, int'(err), 0);
        push({tag, "_chr_pop"}, int'(chr_pop), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        // Both requesting continuously: strict alternation starting from requester 0
        load(0, "1+1=");
        load(1, "1+1=");
        for (int i = 0; i < 4; i++) begin
            core_vals.push_back(2);
            expect_tx(i % 2, 2, 0, "1+1=", 4, 3);
        end
        req = 2'b11;
        wait_dones(4);
        req = 2'b00;
        repeat (3) @(negedge clk);
        load(0, "3+4=");
        core_vals.push_back(7);
        expect_tx(0, 7, 0, "3+4=", 4, 3);
        req = 2'b01;
        wait_dones(1);
        req = 2'b00;
        repeat (2) @(negedge clk);
        stray_valid = 1'b1;
        @(negedge clk);
        stray_valid = 1'b0;
        repeat (2) @(negedge clk);
        push("idle_stray_result", int'(result), 7);
        push("idle_stray_done", int'(done), 0);
        push("idle_stray_grant", int'(grant), 0);
        load(1, "2*3=");
        core_vals.push_back(6);
        expect_tx(1, 6, 0, "2*3=", 4, 3);
        req = 2'b10;
        wait_pop(1);
        stray_valid = 1'b1;
        @(negedge clk);
        stray_valid = 1'b0;
        wait_dones(1);
        req = 2'b00;
        repeat (2) @(negedge clk);
        load(1, "12345678");
        core_vals.push_back(5);
        expect_tx(1, 5, 1, "1234567=", 7, 3);
        req = 2'b10;
        wait_dones(1);
        req = 2'b00;
        repeat (2) @(negedge clk);
        load(0, "5=");
        core_vals.push_back(-1);
        expect_tx(0, 0, 1, "5=", 2, TO + 1);
        req = 2'b01;
        wait_dones(1);
        req = 2'b00;
        repeat (2) @(negedge clk);
        // Pointer now favours requester 1; reset must return it to requester 0
        load(0, "3+4=");
        req = 2'b01;
        wait_pop(0);
        @(negedge clk);
        rst = 1'b1;
        req = 2'b00;
        @(negedge clk);
        check_idle_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        load(0, "1+1=");
        load(1, "1+1=");
        core_vals.push_back(2);
        core_vals.push_back(2);
        expect_tx(0, 2, 0, "1+1=", 4, 3);
        expect_tx(1, 2, 0, "1+1=", 4, 3);
        req = 2'b11;
        wait_dones(2);
        req = 2'b00;
        repeat (3) @(negedge clk);
        push("scoreboard_empty", exp_q.size(), 0);
        push("core_values_consumed", core_vals.size(), 0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
